// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   S_IDLE/S_RUN/S_DONE : 2-bit state codes
//   NIB_W               : datapath width of one serial step (bits)
//   state_t             : FSM state type built on the codes above
package nibble_adder_pkg;

  localparam int unsigned NIB_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder used as the single serial datapath.
//   a, b  : 4-bit addends
//   c_in  : carry in
//   s     : 4-bit sum
//   c_out : carry out of bit 3
module nibble_add4
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             c_in,
  output logic [NIB_W-1:0] s,
  output logic             c_out
);

  logic [NIB_W:0] c;

  assign c[0] = c_in;

  // One full adder per bit, carry rippling upward.
  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign c_out = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds one nibble per clock (LSB first)
// through a single 4-bit ripple adder, holding the carry in a flop.
//   clk, rst_n : clock, async active-low reset
//   start      : accept a, b, c_in when not busy (IDLE or DONE cycle)
//   a, b, c_in : operands and carry into nibble 0
//   busy       : high while nibbles are being processed
//   done       : one-cycle pulse when sum/c_out/ovf have just been updated
//   sum        : result of the last completed operation
//   c_out      : carry out of bit WIDTH-1
//   ovf        : signed overflow of the last completed operation
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = $clog2(NIB);
  localparam int unsigned ACC_W = WIDTH - NIB_W;
  localparam int unsigned LAST  = NIB - 1;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  // Only the lower nibbles are stored; the top nibble goes straight to sum.
  logic [ACC_W-1:0]   acc_r;

  logic [NIB_W-1:0]   nib_a;
  logic [NIB_W-1:0]   nib_b;
  logic [NIB_W-1:0]   nib_s;
  logic               nib_co;
  logic               last;

  assign nib_a = a_r[NIB_W*idx +: NIB_W];
  assign nib_b = b_r[NIB_W*idx +: NIB_W];
  assign last  = (idx == IDX_W'(LAST));

  nibble_add4 u_add4 (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry),
    .s     (nib_s),
    .c_out (nib_co)
  );

  // Sequencer: operand capture, nibble stepping, result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      acc_r <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE (back-to-back ops).
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= c_in;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          carry <= nib_co;
          idx   <= idx + IDX_W'(1);
          if (last) begin
            sum   <= {nib_s, acc_r};
            c_out <= nib_co;
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                     (nib_s[NIB_W-1] != a_r[WIDTH-1]);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            acc_r[NIB_W*idx +: NIB_W] <= nib_s;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and random checks of nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  int tests;
  int fails;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge right after start was dropped; returns negedges until done.
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Issue one op from a negedge, wait for done, check results and pulse width.
  task automatic do_op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input logic tc, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
    int cyc;
    start = 1'b1; a = ta; b = tb; c_in = tc;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; c_in = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'(1));
    wait_done(cyc);
    chk({tag, ".lat"}, 32'(cyc), 32'(4));
    chk({tag, ".sum"}, 32'(sum), 32'(es));
    chk({tag, ".cout"}, 32'(c_out), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".busy_done"}, 32'(busy), 32'(0));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 32'(0));
  endtask

  initial begin
    int cyc;
    int seen;
    logic [WIDTH:0]   gold;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             rc;
    logic             eo;

    tests = 0; fails = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 32'(0));
    chk("rst.done", 32'(done), 32'(0));
    chk("rst.sum", 32'(sum), 32'(0));
    chk("rst.cout", 32'(c_out), 32'(0));
    chk("rst.ovf", 32'(ovf), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 1: basic add, busy held for four cycles
    start = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1) seen++;
      if (i < 3) @(negedge clk);
    end
    chk("t1.busy_cycles", 32'(seen), 32'(4));
    @(negedge clk);
    chk("t1.done", 32'(done), 32'(1));
    chk("t1.sum", 32'(sum), 32'h5555);
    chk("t1.cout", 32'(c_out), 32'(0));
    chk("t1.ovf", 32'(ovf), 32'(0));
    @(negedge clk);
    chk("t1.pulse", 32'(done), 32'(0));

    // 2: carry out of the top, and carry in rippling across nibbles
    do_op("t2a", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("t2b", 16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, 1'b0);

    // 3: signed overflow both directions
    do_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("t3b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // 4: start held through RUN with changing operands
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; c_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; c_in = 1'($urandom);
      chk("t4.busy", 32'(busy), 32'(1));
      chk("t4.nodone", 32'(done), 32'(0));
    end
    @(negedge clk);
    start = 1'b0;
    chk("t4.done", 32'(done), 32'(1));
    chk("t4.sum", 32'(sum), 32'hFFFF);
    chk("t4.cout", 32'(c_out), 32'(0));
    @(negedge clk);
    chk("t4.pulse", 32'(done), 32'(0));
    chk("t4.idle", 32'(busy), 32'(0));

    // 5: back-to-back request in the DONE cycle
    start = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    chk("t5a.lat", 32'(cyc), 32'(4));
    chk("t5a.sum", 32'(sum), 32'h3333);
    start = 1'b1; a = 16'h0001; b = 16'h0002; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("t5.pulse", 32'(done), 32'(0));
    chk("t5.busy", 32'(busy), 32'(1));
    wait_done(cyc);
    chk("t5b.lat", 32'(cyc), 32'(4));
    chk("t5b.sum", 32'(sum), 32'h0003);
    @(negedge clk);

    // 6: reset in the middle of RUN (idx==2)
    start = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6.busy", 32'(busy), 32'(0));
    chk("t6.sum", 32'(sum), 32'(0));
    chk("t6.done", 32'(done), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    chk("t6.nodone", 32'(seen), 32'(0));
    chk("t6.sum_hold", 32'(sum), 32'(0));
    do_op("t6b", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Random ops against the a+b+c_in golden model
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      gold = 17'(ra) + 17'(rb) + 17'(rc);
      eo = (ra[WIDTH-1] == rb[WIDTH-1]) && (gold[WIDTH-1] != ra[WIDTH-1]);
      do_op("rnd", ra, rb, rc, gold[WIDTH-1:0], gold[WIDTH], eo);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
